// File: rtl/tds_word_aligner.sv
// Word aligner for the raw 20-bit GTP RX stream: finds the sync word at any bit offset,
// confirms its frame period, and then emits aligned words with a frame-start marker.

module tds_word_aligner_cmp #(
  parameter logic [19:0] SYNC_WORD = 20'h3EB05
) (
  input  logic [19:0] cand,
  output logic        match
);
  assign match = (cand == SYNC_WORD);
endmodule

module tds_word_aligner #(
  parameter logic [19:0] SYNC_WORD  = 20'h3EB05,
  parameter int          FRAME_LEN  = 8,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 3
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic [19:0] RX_DATA_IN,
  input  logic        realign,
  output logic [19:0] data_out,
  output logic        data_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [1:0]  state,
  output logic [4:0]  offset,
  output logic [7:0]  relock_cnt
);
  localparam int          NUM_OFF  = 20;
  localparam int          PW       = $clog2(FRAME_LEN);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} st_t;

  st_t                          st_q, st_d;
  logic [PW-1:0]                pos_q, pos_d, pos_inc;
  logic [4:0]                   off_q, off_d, hit_off;
  logic [3:0]                   good_q, good_d, miss_q, miss_d;
  logic [7:0]                   relock_q, relock_d;
  logic                         bump, ckpt, any_match, match_sel, dv_d, fs_d;
  logic [19:0]                  word_d;
  logic [38:0]                  win;
  logic [NUM_OFF-1:0][19:0]     cand;
  logic [NUM_OFF-1:0]           match;

  // The live word's LSB never falls inside a candidate, so it is left out of the window.
  assign win = {word_d, RX_DATA_IN[19:1]};

  for (genvar k = 0; k < NUM_OFF; k++) begin : g_off
    assign cand[k] = win[38-k -: 20];
    tds_word_aligner_cmp #(.SYNC_WORD(SYNC_WORD)) u_cmp (
      .cand  (cand[k]),
      .match (match[k])
    );
  end

  always_comb begin
    hit_off = '0;
    for (int k = NUM_OFF-1; k >= 0; k--)
      if (match[k]) hit_off = 5'(k);
  end

  assign any_match = |match;
  assign match_sel = match[off_q];
  assign ckpt      = (pos_q == '0);
  assign pos_inc   = (pos_q == PW'(FRAME_LEN-1)) ? '0 : pos_q + PW'(1);

  always_comb begin
    st_d     = st_q;
    pos_d    = pos_q;
    off_d    = off_q;
    good_d   = good_q;
    miss_d   = miss_q;
    relock_d = relock_q;
    bump     = 1'b0;
    case (st_q)
      HUNT: begin
        if (any_match) begin
          off_d  = hit_off;
          pos_d  = PW'(1);
          good_d = 4'd1;
          miss_d = '0;
          st_d   = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        pos_d = pos_inc;
        if (ckpt) begin
          if (match_sel) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) begin
              st_d   = LOCKED;
              miss_d = '0;
            end
          end else begin
            st_d   = HUNT;
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        pos_d = pos_inc;
        if (ckpt) begin
          if (match_sel) begin
            miss_d = '0;
          end else begin
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == UNLOCK_N) begin
              st_d   = HUNT;
              miss_d = '0;
              good_d = '0;
              bump   = 1'b1;
            end
          end
        end
      end
      default: st_d = HUNT;
    endcase
    // realign overrides whatever the FSM decided; a LOCKED exit is counted once.
    if (realign) begin
      st_d   = HUNT;
      pos_d  = '0;
      off_d  = off_q;
      good_d = '0;
      miss_d = '0;
      bump   = (st_q == LOCKED);
    end
    if (bump && relock_q != 8'hFF) relock_d = relock_q + 8'd1;
  end

  assign dv_d = (st_q == LOCKED) && (st_d == LOCKED);
  assign fs_d = dv_d && ckpt && match_sel;

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      st_q        <= HUNT;
      pos_q       <= '0;
      off_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      relock_q    <= '0;
      word_d      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      st_q        <= st_d;
      pos_q       <= pos_d;
      off_q       <= off_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      relock_q    <= relock_d;
      word_d      <= RX_DATA_IN;
      data_out    <= cand[off_q];
      data_valid  <= dv_d;
      frame_start <= fs_d;
      locked      <= (st_d == LOCKED);
    end
  end

  assign state      = st_q;
  assign offset     = off_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_tds_word_aligner.sv
// Directed bench for tds_word_aligner: framed streams at bit shifts 0 and 7, sync
// corruption, late sync, realign and asynchronous reset, with hand-derived timing.

module tb_tds_word_aligner;
  localparam logic [19:0] SYNC = 20'h3EB05;

  logic        clk = 1'b0, rst_n = 1'b1, realign = 1'b0;
  logic [19:0] rx = '0;
  logic [19:0] data_out;
  logic        data_valid, frame_start, locked;
  logic [1:0]  state;
  logic [4:0]  offset;
  logic [7:0]  relock_cnt;

  int total = 0, bad = 0;
  logic [19:0] aw [0:1023];
  int cyc, sh, ph, kill_lo, kill_hi, rq_idx, fs_seen, b;

  tds_word_aligner dut (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .RX_DATA_IN     (rx),
    .realign        (realign),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .frame_start    (frame_start),
    .locked         (locked),
    .state          (state),
    .offset         (offset),
    .relock_cnt     (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (word %0d)", tag, got, exp, cyc);
    end
  endtask

  // Data words keep a 12-bit zero head and never hold five ones in a row, so the
  // sync pattern cannot appear at any bit offset outside real sync positions.
  function automatic logic [19:0] word_at(input int k);
    logic [7:0] lo;
    lo = k[7:0];
    if (k >= ph && (k - ph) % 8 == 0)
      return (k >= kill_lo && k <= kill_hi) ? 20'h0 : SYNC;
    return {12'h0, lo[7:4], 1'b0, lo[2:0]};
  endfunction

  task automatic tick();
    logic [39:0] w;
    aw[cyc] = word_at(cyc);
    w = {aw[cyc-1], aw[cyc]} >> sh;
    rx = w[19:0];
    realign = (cyc == rq_idx);
    @(posedge clk); #1;
    realign = 1'b0;
    if (data_valid) begin
      chk("data", data_out, aw[cyc-1]);
      chk("fstart", frame_start, aw[cyc-1] == SYNC);
      if (frame_start) fs_seen++;
    end else begin
      chk("fstart_idle", frame_start, 0);
    end
    cyc++;
  endtask

  task automatic send_to(input int last);
    while (cyc <= last) tick();
  endtask

  task automatic do_reset();
    rx = '0;
    realign = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_dout", data_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_lock", locked, 0);
    chk("rst_state", state, 0);
    chk("rst_off", offset, 0);
    chk("rst_relock", relock_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aw[0] = '0;
    cyc = 1;
    kill_lo = -1;
    kill_hi = -1;
    rq_idx = -1;
  endtask

  task automatic acquire(input int exp_off);
    int s;
    s = cyc + 3;
    ph = s;
    fs_seen = 0;
    send_to(s);    chk("hunt_wait", state, 0);
    send_to(s+1);  chk("verify", state, 1);
                   chk("offset", offset, exp_off);
    send_to(s+24); chk("not_locked", locked, 0);
    send_to(s+25); chk("locked", locked, 1);
                   chk("state_lk", state, 2);
                   chk("dv_first", data_valid, 0);
    send_to(s+26); chk("dv", data_valid, 1);
    send_to(s+60); chk("fs_count", fs_seen, 4);
  endtask

  initial begin
    #2;
    sh = 0;
    do_reset();

    // offset 0 acquisition
    acquire(0);
    b = ph;

    // two missed syncs are tolerated, three force HUNT
    kill_lo = b+64;  kill_hi = b+72;
    send_to(b+100); chk("miss2_lock", locked, 1);
                    chk("miss2_relock", relock_cnt, 0);
    kill_lo = b+104; kill_hi = b+120;
    send_to(b+120); chk("miss3_pre", locked, 1);
    send_to(b+121); chk("miss3_hunt", state, 0);
                    chk("miss3_relock", relock_cnt, 1);
                    chk("miss3_dv", data_valid, 0);
    send_to(b+152); chk("reacq_verify", state, 1);
    send_to(b+153); chk("reacq_lock", locked, 1);

    // realign on top of a third miss counts one relock
    kill_lo = b+160; kill_hi = b+176;
    rq_idx = b+177;
    send_to(b+176); chk("rq_pre", locked, 1);
    send_to(b+177); chk("rq_hunt", state, 0);
                    chk("rq_relock", relock_cnt, 2);
    rq_idx = b+185;
    send_to(b+185); chk("rq_hunt2", state, 0);
                    chk("rq_relock2", relock_cnt, 2);
    send_to(b+193); chk("rq_verify", state, 1);

    // late sync during VERIFY
    send_to(b+201);
    ph = b+209;
    send_to(b+208); chk("late_verify", state, 1);
    send_to(b+209); chk("late_hunt", state, 0);
    send_to(b+210); chk("late_reacq", state, 1);
    send_to(b+233); chk("late_nolock", locked, 0);
    send_to(b+234); chk("late_lock", locked, 1);
                    chk("late_relock", relock_cnt, 2);

    // asynchronous reset mid-frame, then full re-acquisition
    send_to(b+240);
    do_reset();
    acquire(0);

    // stream shifted by 7 bits
    do_reset();
    sh = 7;
    acquire(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
